// File: rtl/uart_cmd_parser_if.sv
// Byte-stream, settings and response signals between the UART path and the command parser.
interface uart_cmd_parser_if;
  logic [7:0] i_rx_byte;
  logic       i_rx_valid;
  logic [3:0] o_pattern;
  logic [8:0] o_color;
  logic       o_cmd_stb;
  logic       o_err_stb;
  logic [7:0] o_resp_byte;
  logic       o_resp_valid;
  logic       i_resp_ready;
  logic       o_resp_drop;

  modport master (
    output i_rx_byte, i_rx_valid, i_resp_ready,
    input  o_pattern, o_color, o_cmd_stb, o_err_stb, o_resp_byte, o_resp_valid, o_resp_drop
  );

  modport slave (
    input  i_rx_byte, i_rx_valid, i_resp_ready,
    output o_pattern, o_color, o_cmd_stb, o_err_stb, o_resp_byte, o_resp_valid, o_resp_drop
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// ASCII command parser: "P h <term>" sets the pattern, "C r g b <term>" sets the colour,
// and each completed or failed command queues a one-byte 'K' / '?' response.
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter int unsigned CNT_W          = 22
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  uart_cmd_parser_if.slave bus
);

  localparam int unsigned ARG_W = 9;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_ESC = 8'h1B;
  localparam logic [7:0] CH_K   = 8'h4B;
  localparam logic [7:0] CH_Q   = 8'h3F;

  typedef enum logic [1:0] {IDLE, ARG, TERM} state_t;

  state_t             state, state_nxt;
  logic [1:0]         need, need_nxt;
  logic               is_color, is_color_nxt;
  logic [ARG_W-1:0]   arg, arg_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [3:0]         pattern, pattern_nxt;
  logic [8:0]         color, color_nxt;
  logic               cmd_stb, cmd_stb_nxt;
  logic               err_stb, err_stb_nxt;
  logic [7:0]         resp_byte, resp_byte_nxt;
  logic               resp_valid, resp_valid_nxt;
  logic               resp_drop, resp_drop_nxt;

  logic [7:0] rx;
  logic       is_term, is_p, is_c, hex_ok, oct_ok;
  logic [3:0] hex_val;

  // Byte classification
  always_comb begin
    rx      = bus.i_rx_byte;
    is_term = (rx == CH_CR) || (rx == CH_LF);
    is_p    = (rx == 8'h50) || (rx == 8'h70);
    is_c    = (rx == 8'h43) || (rx == 8'h63);
    oct_ok  = (rx >= 8'h30) && (rx <= 8'h37);
    hex_ok  = 1'b1;
    hex_val = rx[3:0];
    if ((rx >= 8'h30) && (rx <= 8'h39)) begin
      hex_val = rx[3:0];
    end else if (((rx >= 8'h41) && (rx <= 8'h46)) || ((rx >= 8'h61) && (rx <= 8'h66))) begin
      hex_val = rx[3:0] + 4'd9;
    end else begin
      hex_ok = 1'b0;
    end
  end

  // Parser next state, settings and response queue
  always_comb begin
    state_nxt      = state;
    need_nxt       = need;
    is_color_nxt   = is_color;
    arg_nxt        = arg;
    cnt_nxt        = '0;
    pattern_nxt    = pattern;
    color_nxt      = color;
    cmd_stb_nxt    = 1'b0;
    err_stb_nxt    = 1'b0;
    resp_byte_nxt  = resp_byte;
    resp_valid_nxt = resp_valid;
    resp_drop_nxt  = 1'b0;

    if (state != IDLE) cnt_nxt = cnt + CNT_W'(1);

    if (bus.i_rx_valid) begin
      cnt_nxt = '0;
      if (rx == CH_ESC) begin
        state_nxt = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (is_p || is_c) begin
              state_nxt    = ARG;
              need_nxt     = is_c ? 2'd3 : 2'd1;
              is_color_nxt = is_c;
              arg_nxt      = '0;
            end else if (!(is_term || (rx == CH_SP))) begin
              err_stb_nxt = 1'b1;
            end
          end
          ARG: begin
            if (is_color ? oct_ok : hex_ok) begin
              arg_nxt  = is_color ? {arg[5:0], rx[2:0]} : {5'd0, hex_val};
              need_nxt = need - 2'd1;
              if (need == 2'd1) state_nxt = TERM;
            end else begin
              err_stb_nxt = 1'b1;
              state_nxt   = IDLE;
            end
          end
          TERM: begin
            state_nxt = IDLE;
            if (is_term) begin
              cmd_stb_nxt = 1'b1;
              if (is_color) color_nxt = arg;
              else          pattern_nxt = arg[3:0];
            end else begin
              err_stb_nxt = 1'b1;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end else if ((state != IDLE) && (cnt == CNT_W'(TIMEOUT_CYCLES - 2))) begin
      // next count would reach TIMEOUT_CYCLES-1: abandon the command
      err_stb_nxt = 1'b1;
      state_nxt   = IDLE;
      cnt_nxt     = '0;
    end

    if (resp_valid && bus.i_resp_ready) resp_valid_nxt = 1'b0;
    // A pending response is never overwritten, even in its handshake cycle
    if (cmd_stb_nxt || err_stb_nxt) begin
      if (resp_valid) begin
        resp_drop_nxt = 1'b1;
      end else begin
        resp_valid_nxt = 1'b1;
        resp_byte_nxt  = cmd_stb_nxt ? CH_K : CH_Q;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      need       <= '0;
      is_color   <= 1'b0;
      arg        <= '0;
      cnt        <= '0;
      pattern    <= '0;
      color      <= '0;
      cmd_stb    <= 1'b0;
      err_stb    <= 1'b0;
      resp_byte  <= '0;
      resp_valid <= 1'b0;
      resp_drop  <= 1'b0;
    end else begin
      state      <= state_nxt;
      need       <= need_nxt;
      is_color   <= is_color_nxt;
      arg        <= arg_nxt;
      cnt        <= cnt_nxt;
      pattern    <= pattern_nxt;
      color      <= color_nxt;
      cmd_stb    <= cmd_stb_nxt;
      err_stb    <= err_stb_nxt;
      resp_byte  <= resp_byte_nxt;
      resp_valid <= resp_valid_nxt;
      resp_drop  <= resp_drop_nxt;
    end
  end

  assign bus.o_pattern    = pattern;
  assign bus.o_color      = color;
  assign bus.o_cmd_stb    = cmd_stb;
  assign bus.o_err_stb    = err_stb;
  assign bus.o_resp_byte  = resp_byte;
  assign bus.o_resp_valid = resp_valid;
  assign bus.o_resp_drop  = resp_drop;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: fixed vector table, corner-case sequences and random
// traffic checked cycle by cycle against a command-buffer reference model.
module tb_uart_cmd_parser;

  localparam int unsigned TO = 16;
  localparam logic [7:0] CR = 8'h0D, LF = 8'h0A, SP = 8'h20, ESC = 8'h1B;
  localparam logic [7:0] CH_P = 8'h50, CH_C = 8'h43, CH_0 = 8'h30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  uart_cmd_parser_if bus();

  uart_cmd_parser #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [7:0] cmd_q[$];
  int         cyc = 0, last_byte_cyc = 0;
  logic [3:0] m_pat;
  logic [8:0] m_col;
  logic [7:0] m_rb;
  bit         m_cmd, m_err, m_rv, m_drop;

  typedef struct {
    bit v; logic [7:0] b; bit r;
    logic [3:0] pat; logic [8:0] col; bit cmd; bit err; bit rv; logic [7:0] rb; bit drop;
  } vec_t;
  vec_t vecs[25];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] upcase(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
  endfunction

  function automatic int hex_value(input logic [7:0] c);
    logic [7:0] u;
    u = upcase(c);
    if (u >= 8'h30 && u <= 8'h39) return int'(u) - 48;
    if (u >= 8'h41 && u <= 8'h46) return int'(u) - 55;
    return -1;
  endfunction

  function automatic bit digit_ok(input logic [7:0] kind, input logic [7:0] c);
    if (kind == CH_P) return hex_value(c) >= 0;
    return (c >= 8'h30) && (c <= 8'h37);
  endfunction

  task automatic model_reset();
    cmd_q.delete();
    m_pat = '0; m_col = '0; m_rb = '0;
    m_cmd = 0; m_err = 0; m_rv = 0; m_drop = 0;
    cyc = 0; last_byte_cyc = 0;
  endtask

  // Per-cycle model: buffer the command text and judge it once complete
  task automatic model_step(input bit v, input logic [7:0] b, input bit r);
    bit prev_rv;
    int len;
    logic [7:0] c;
    prev_rv = m_rv;
    m_cmd = 0; m_err = 0; m_drop = 0;
    if (v) begin
      last_byte_cyc = cyc;
      c = upcase(b);
      if (b == ESC) begin
        cmd_q.delete();
      end else if (cmd_q.size() == 0) begin
        if (c == CH_P || c == CH_C) cmd_q.push_back(c);
        else if (!(b == CR || b == LF || b == SP)) m_err = 1;
      end else begin
        len = (cmd_q[0] == CH_P) ? 3 : 5;
        if (cmd_q.size() == len - 1) begin
          if (b == CR || b == LF) begin
            m_cmd = 1;
            if (cmd_q[0] == CH_P) m_pat = 4'(hex_value(cmd_q[1]));
            else m_col = 9'((int'(cmd_q[1]) - 48) * 64 + (int'(cmd_q[2]) - 48) * 8 + (int'(cmd_q[3]) - 48));
          end else begin
            m_err = 1;
          end
          cmd_q.delete();
        end else if (digit_ok(cmd_q[0], b)) begin
          cmd_q.push_back(b);
        end else begin
          m_err = 1;
          cmd_q.delete();
        end
      end
    end else if (cmd_q.size() != 0 && (cyc - last_byte_cyc) == int'(TO) - 1) begin
      m_err = 1;
      cmd_q.delete();
    end
    if (prev_rv && r) m_rv = 0;
    if (m_cmd || m_err) begin
      if (prev_rv) m_drop = 1;
      else begin
        m_rv = 1;
        m_rb = m_cmd ? 8'h4B : 8'h3F;
      end
    end
    cyc++;
  endtask

  task automatic check_model();
    check("pattern", 16'(bus.o_pattern), 16'(m_pat));
    check("color", 16'(bus.o_color), 16'(m_col));
    check("cmd_stb", 16'(bus.o_cmd_stb), 16'(m_cmd));
    check("err_stb", 16'(bus.o_err_stb), 16'(m_err));
    check("resp_valid", 16'(bus.o_resp_valid), 16'(m_rv));
    check("resp_byte", 16'(bus.o_resp_byte), 16'(m_rb));
    check("resp_drop", 16'(bus.o_resp_drop), 16'(m_drop));
  endtask

  // One clock: drive, let the edge happen, advance the model, sample 1 time unit later
  task automatic tick(input bit v, input logic [7:0] b, input bit r);
    bus.i_rx_valid   = v;
    bus.i_rx_byte    = b;
    bus.i_resp_ready = r;
    @(posedge clk);
    model_step(v, b, r);
    #1;
    check_model();
  endtask

  function automatic vec_t mk(input bit v, input logic [7:0] b, input bit r, input logic [3:0] pat,
                              input logic [8:0] col, input bit cmd, input bit err, input bit rv,
                              input logic [7:0] rb, input bit drop);
    vec_t t;
    t.v = v; t.b = b; t.r = r; t.pat = pat; t.col = col;
    t.cmd = cmd; t.err = err; t.rv = rv; t.rb = rb; t.drop = drop;
    return t;
  endfunction

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 15))
      0: return 8'h50;
      1: return 8'h70;
      2: return 8'h43;
      3: return 8'h63;
      4, 5, 6: return CH_0 + 8'($urandom_range(0, 9));
      7: return 8'h41 + 8'($urandom_range(0, 6));
      8: return 8'h61 + 8'($urandom_range(0, 6));
      9: return CR;
      10: return LF;
      11: return SP;
      12: return ESC;
      13: return 8'($urandom_range(0, 255));
      default: return CH_0 + 8'($urandom_range(0, 7));
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first_err;
    bit err_seen;

    vecs[0]  = mk(1, 8'h50, 1, 4'h0, 9'h000, 0, 0, 0, 8'h00, 0);
    vecs[1]  = mk(1, 8'h35, 1, 4'h0, 9'h000, 0, 0, 0, 8'h00, 0);
    vecs[2]  = mk(1, CR,    1, 4'h5, 9'h000, 1, 0, 1, 8'h4B, 0);
    vecs[3]  = mk(0, 8'h00, 1, 4'h5, 9'h000, 0, 0, 0, 8'h4B, 0);
    vecs[4]  = mk(1, 8'h63, 1, 4'h5, 9'h000, 0, 0, 0, 8'h4B, 0);
    vecs[5]  = mk(1, 8'h37, 1, 4'h5, 9'h000, 0, 0, 0, 8'h4B, 0);
    vecs[6]  = mk(1, 8'h30, 1, 4'h5, 9'h000, 0, 0, 0, 8'h4B, 0);
    vecs[7]  = mk(1, 8'h33, 1, 4'h5, 9'h000, 0, 0, 0, 8'h4B, 0);
    vecs[8]  = mk(1, LF,    1, 4'h5, 9'h1C3, 1, 0, 1, 8'h4B, 0);
    vecs[9]  = mk(1, 8'h50, 1, 4'h5, 9'h1C3, 0, 0, 0, 8'h4B, 0);
    vecs[10] = mk(1, 8'h41, 1, 4'h5, 9'h1C3, 0, 0, 0, 8'h4B, 0);
    vecs[11] = mk(1, CR,    1, 4'hA, 9'h1C3, 1, 0, 1, 8'h4B, 0);
    vecs[12] = mk(1, 8'h43, 1, 4'hA, 9'h1C3, 0, 0, 0, 8'h4B, 0);
    vecs[13] = mk(1, 8'h38, 1, 4'hA, 9'h1C3, 0, 1, 1, 8'h3F, 0);
    vecs[14] = mk(1, 8'h50, 1, 4'hA, 9'h1C3, 0, 0, 0, 8'h3F, 0);
    vecs[15] = mk(1, 8'h33, 1, 4'hA, 9'h1C3, 0, 0, 0, 8'h3F, 0);
    vecs[16] = mk(1, CR,    1, 4'h3, 9'h1C3, 1, 0, 1, 8'h4B, 0);
    vecs[17] = mk(0, 8'h00, 1, 4'h3, 9'h1C3, 0, 0, 0, 8'h4B, 0);
    vecs[18] = mk(1, 8'h50, 0, 4'h3, 9'h1C3, 0, 0, 0, 8'h4B, 0);
    vecs[19] = mk(1, 8'h31, 0, 4'h3, 9'h1C3, 0, 0, 0, 8'h4B, 0);
    vecs[20] = mk(1, CR,    0, 4'h1, 9'h1C3, 1, 0, 1, 8'h4B, 0);
    vecs[21] = mk(1, 8'h58, 0, 4'h1, 9'h1C3, 0, 1, 1, 8'h4B, 1);
    vecs[22] = mk(0, 8'h00, 0, 4'h1, 9'h1C3, 0, 0, 1, 8'h4B, 0);
    vecs[23] = mk(0, 8'h00, 1, 4'h1, 9'h1C3, 0, 0, 0, 8'h4B, 0);
    vecs[24] = mk(0, 8'h00, 0, 4'h1, 9'h1C3, 0, 0, 0, 8'h4B, 0);

    bus.i_rx_valid = 1'b0; bus.i_rx_byte = 8'h00; bus.i_resp_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_model();
    @(negedge clk);
    rst_n = 1'b1;

    // fixed vectors
    for (int i = 0; i < 25; i++) begin
      tick(vecs[i].v, vecs[i].b, vecs[i].r);
      check($sformatf("vec%0d_pattern", i), 16'(bus.o_pattern), 16'(vecs[i].pat));
      check($sformatf("vec%0d_color", i), 16'(bus.o_color), 16'(vecs[i].col));
      check($sformatf("vec%0d_cmd", i), 16'(bus.o_cmd_stb), 16'(vecs[i].cmd));
      check($sformatf("vec%0d_err", i), 16'(bus.o_err_stb), 16'(vecs[i].err));
      check($sformatf("vec%0d_rvalid", i), 16'(bus.o_resp_valid), 16'(vecs[i].rv));
      check($sformatf("vec%0d_rbyte", i), 16'(bus.o_resp_byte), 16'(vecs[i].rb));
      check($sformatf("vec%0d_drop", i), 16'(bus.o_resp_drop), 16'(vecs[i].drop));
    end

    // ESC mid-command aborts silently and leaves the parser ready for a new command
    tick(1, 8'h43, 1); tick(1, 8'h31, 1); tick(1, 8'h32, 1); tick(1, ESC, 1);
    check("esc_no_cmd", 16'(bus.o_cmd_stb), 16'h0);
    check("esc_no_err", 16'(bus.o_err_stb), 16'h0);
    check("esc_no_resp", 16'(bus.o_resp_valid), 16'h0);
    check("esc_color_kept", 16'(bus.o_color), 16'h1C3);
    tick(1, 8'h50, 1); tick(1, 8'h34, 1); tick(1, CR, 1);
    check("esc_then_p4", 16'(bus.o_pattern), 16'h4);
    tick(0, 8'h00, 1);

    // timeout: error strobe appears on the 15th idle cycle after 'P'
    tick(1, 8'h70, 1);
    first_err = -1;
    for (int i = 1; i <= 40; i++) begin
      tick(0, 8'h00, 1);
      if (bus.o_err_stb === 1'b1 && first_err < 0) first_err = i;
    end
    check("timeout_latency", 16'(first_err), 16'd15);

    // digit landing exactly on the timeout cycle is accepted
    err_seen = 0;
    tick(1, 8'h50, 1);
    for (int i = 0; i < 14; i++) begin
      tick(0, 8'h00, 1);
      if (bus.o_err_stb === 1'b1) err_seen = 1;
    end
    tick(1, 8'h37, 1);
    if (bus.o_err_stb === 1'b1) err_seen = 1;
    tick(1, CR, 1);
    if (bus.o_err_stb === 1'b1) err_seen = 1;
    check("late_digit_no_err", 16'(err_seen), 16'h0);
    check("late_digit_pattern", 16'(bus.o_pattern), 16'h7);
    tick(0, 8'h00, 1);

    // asynchronous reset in the middle of "C1"
    tick(1, 8'h43, 1); tick(1, 8'h31, 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_pattern", 16'(bus.o_pattern), 16'h0);
    check("rst_color", 16'(bus.o_color), 16'h0);
    check("rst_cmd", 16'(bus.o_cmd_stb), 16'h0);
    check("rst_err", 16'(bus.o_err_stb), 16'h0);
    check("rst_rvalid", 16'(bus.o_resp_valid), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1, CR, 1);
    check("rst_idle_cr", 16'(bus.o_err_stb), 16'h0);
    tick(1, 8'h50, 1); tick(1, 8'h32, 1); tick(1, LF, 1);
    check("rst_then_p2", 16'(bus.o_pattern), 16'h2);

    // random traffic with occasional idle gaps around the timeout boundary
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        int gap = $urandom_range(13, 18);
        for (int j = 0; j < gap; j++) tick(0, 8'h00, $urandom_range(0, 3) != 0);
      end else begin
        tick($urandom_range(0, 2) != 0, rand_byte(), $urandom_range(0, 3) != 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
